// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the main-memory arbiter.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 26;
   localparam int LINE_W_DEF = 128;

   typedef enum logic [1:0] {
      IDLE,
      GRANT_I,
      GRANT_D,
      TURN
   } state_t;

   typedef enum logic {
      GNT_I,
      GNT_D
   } grant_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Stall watchdog: counts cycles while a grant is outstanding and flags expiry
// in the TIMEOUT-th cycle. TIMEOUT = 0 disables it.
module mem_arb_watchdog #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   // The count lags the grant cycle number by one, so the last allowed
   // cycle is the one where the count equals TIMEOUT-1.
   localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [CNT_W-1:0] count;

   // Cycle counter, cleared whenever no grant is outstanding.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expired = (TIMEOUT != 0) && en && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single line-wide memory port between the I-cache miss path
// and the D-cache miss/writeback path, one transaction at a time, with a
// turnaround cycle between transactions and a stall watchdog.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int LINE_W  = LINE_W_DEF,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              reqI,
   input  logic [ADDR_W-1:0] addrI,
   input  logic              flushI,
   output logic [LINE_W-1:0] rdataI,
   output logic              readyI,
   input  logic              reqD,
   input  logic              weD,
   input  logic [ADDR_W-1:0] addrD,
   input  logic [LINE_W-1:0] wdataD,
   output logic [LINE_W-1:0] rdataD,
   output logic              readyD,
   output logic              ackD,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_rready,
   input  logic              mem_wack,
   output logic              busy,
   output logic              timeout_err
);

   state_t            state;
   grant_t            last_grant;
   logic              drop;
   logic              want_i;
   logic              want_d;
   logic              pick_d;
   logic              in_grant;
   logic              resp;
   logic              expired;
   logic [LINE_W-1:0] resp_data;

   assign in_grant = (state == GRANT_I) || (state == GRANT_D);

   mem_arb_watchdog #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clr     (!in_grant),
      .en      (in_grant),
      .expired (expired)
   );

   // Request qualification and the round-robin pick, plus the expected response.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      want_i    = reqI && !flushI;
      want_d    = reqD;
      pick_d    = want_d && (!want_i || (last_grant == GNT_I));
      resp      = mem_we ? mem_wack : mem_rready;
      resp_data = resp ? mem_rdata : '0;
   end

   // Arbitration FSM with registered memory-side and cache-side outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         last_grant  <= GNT_I;
         drop        <= 1'b0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         rdataI      <= '0;
         readyI      <= 1'b0;
         rdataD      <= '0;
         readyD      <= 1'b0;
         ackD        <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         // NOTE: state uses non-blocking assignments; the pulse outputs default low here and are raised below for one cycle.
         readyI <= 1'b0;
         readyD <= 1'b0;
         ackD   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (want_i || want_d) begin
                  mem_req <= 1'b1;
                  busy    <= 1'b1;
                  drop    <= 1'b0;
                  if (pick_d) begin
                     state      <= GRANT_D;
                     last_grant <= GNT_D;
                     mem_we     <= weD;
                     mem_addr   <= addrD;
                     mem_wdata  <= wdataD;
                  end else begin
                     state      <= GRANT_I;
                     last_grant <= GNT_I;
                     mem_we     <= 1'b0;
                     mem_addr   <= addrI;
                     mem_wdata  <= '0;
                  end
               end
            end
            GRANT_I, GRANT_D: begin
               // A real response beats a simultaneous watchdog expiry.
               if (resp || expired) begin
                  state   <= TURN;
                  mem_req <= 1'b0;
                  if (!resp) begin
                     timeout_err <= 1'b1;
                  end
                  if (state == GRANT_I) begin
                     rdataI <= resp_data;
                     readyI <= !(drop || flushI);
                  end else if (mem_we) begin
                     ackD <= 1'b1;
                  end else begin
                     rdataD <= resp_data;
                     readyD <= 1'b1;
                  end
               end else if ((state == GRANT_I) && flushI) begin
                  drop <= 1'b1;
               end
            end
            TURN: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against a transaction-level model of the arbiter.
module tb_mem_arbiter;

   localparam int AW = 26;
   localparam int LW = 128;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          reqI = 1'b0;
   logic [AW-1:0] addrI = '0;
   logic          flushI = 1'b0;
   logic [LW-1:0] rdataI;
   logic          readyI;
   logic          reqD = 1'b0;
   logic          weD = 1'b0;
   logic [AW-1:0] addrD = '0;
   logic [LW-1:0] wdataD = '0;
   logic [LW-1:0] rdataD;
   logic          readyD;
   logic          ackD;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [LW-1:0] mem_wdata;
   logic [LW-1:0] mem_rdata = '0;
   logic          mem_rready = 1'b0;
   logic          mem_wack = 1'b0;
   logic          busy;
   logic          timeout_err;

   int n_vec = 0;
   int n_mis = 0;
   bit cmp_en = 1'b0;
   bit silent = 1'b0;

   always #5 clk = ~clk;

   mem_arbiter #(
      .ADDR_W  (AW),
      .LINE_W  (LW),
      .TIMEOUT (TO),
      .CNT_W   (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .reqI        (reqI),
      .addrI       (addrI),
      .flushI      (flushI),
      .rdataI      (rdataI),
      .readyI      (readyI),
      .reqD        (reqD),
      .weD         (weD),
      .addrD       (addrD),
      .wdataD      (wdataD),
      .rdataD      (rdataD),
      .readyD      (readyD),
      .ackD        (ackD),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_rready  (mem_rready),
      .mem_wack    (mem_wack),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   // Transaction-level view: which phase of a transaction we are in, who owns
   // it, how many cycles it has waited, and what each output must show.
   typedef struct {
      int            phase;   // 0 idle, 1 waiting for memory, 2 turnaround
      bit            own_d;
      bit            last_d;
      int            waited;
      bit            drop;
      logic          mem_req;
      logic          mem_we;
      logic [AW-1:0] mem_addr;
      logic [LW-1:0] mem_wdata;
      logic [LW-1:0] rdataI;
      logic [LW-1:0] rdataD;
      logic          readyI;
      logic          readyD;
      logic          ackD;
      logic          busy;
      logic          terr;
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t r;
      r.phase = 0;     r.own_d = 1'b0;  r.last_d = 1'b0; r.waited = 0;
      r.drop = 1'b0;   r.mem_req = 1'b0; r.mem_we = 1'b0; r.mem_addr = '0;
      r.mem_wdata = '0; r.rdataI = '0;  r.rdataD = '0;   r.readyI = 1'b0;
      r.readyD = 1'b0; r.ackD = 1'b0;   r.busy = 1'b0;   r.terr = 1'b0;
      return r;
   endfunction

   function automatic model_t model_next(model_t cur);
      model_t        n;
      bit            want_i;
      bit            want_d;
      bit            pick_d;
      bit            got;
      logic [LW-1:0] data;
      n = cur;
      n.readyI = 1'b0;
      n.readyD = 1'b0;
      n.ackD   = 1'b0;
      if (cur.phase == 0) begin
         want_i = reqI && !flushI;
         want_d = reqD;
         if (want_i || want_d) begin
            // Contention goes to whichever side did not win last time.
            pick_d      = want_d && !(want_i && cur.last_d);
            n.phase     = 1;
            n.own_d     = pick_d;
            n.last_d    = pick_d;
            n.waited    = 0;
            n.drop      = 1'b0;
            n.busy      = 1'b1;
            n.mem_req   = 1'b1;
            n.mem_addr  = pick_d ? addrD : addrI;
            n.mem_we    = pick_d ? weD : 1'b0;
            n.mem_wdata = pick_d ? wdataD : '0;
         end
      end else if (cur.phase == 1) begin
         n.waited = cur.waited + 1;
         got = cur.mem_we ? mem_wack : mem_rready;
         if (got || (TO != 0 && n.waited >= TO)) begin
            data      = got ? mem_rdata : '0;
            n.phase   = 2;
            n.mem_req = 1'b0;
            if (!got) n.terr = 1'b1;
            if (!cur.own_d) begin
               n.rdataI = data;
               n.readyI = !(cur.drop || flushI);
            end else if (cur.mem_we) begin
               n.ackD = 1'b1;
            end else begin
               n.rdataD = data;
               n.readyD = 1'b1;
            end
         end else if (!cur.own_d && flushI) begin
            n.drop = 1'b1;
         end
      end else begin
         n.phase = 0;
         n.busy  = 1'b0;
      end
      return n;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) m <= model_reset();
      else        m <= model_next(m);
   end

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("mem_req",     LW'(mem_req),     LW'(m.mem_req));
         check("mem_we",      LW'(mem_we),      LW'(m.mem_we));
         check("mem_addr",    LW'(mem_addr),    LW'(m.mem_addr));
         check("mem_wdata",   mem_wdata,        m.mem_wdata);
         check("rdataI",      rdataI,           m.rdataI);
         check("readyI",      LW'(readyI),      LW'(m.readyI));
         check("rdataD",      rdataD,           m.rdataD);
         check("readyD",      LW'(readyD),      LW'(m.readyD));
         check("ackD",        LW'(ackD),        LW'(m.ackD));
         check("busy",        LW'(busy),        LW'(m.busy));
         check("timeout_err", LW'(timeout_err), LW'(m.terr));
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_req();
      int n = 0;
      while (mem_req !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check("wait_req", LW'(mem_req), LW'(1));
   endtask

   // Waits for the grant, answers it with the matching pulse, and leaves the
   // bench at the turnaround cycle.
   task automatic serve(input logic [LW-1:0] d, output logic [AW-1:0] a);
      wait_req();
      a = mem_addr;
      if (mem_we) mem_wack = 1'b1;
      else        mem_rready = 1'b1;
      mem_rdata = d;
      step();
      mem_wack   = 1'b0;
      mem_rready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL time_limit: simulation did not finish");
      $fatal(1, "time limit");
   end

   initial begin
      logic [AW-1:0] a;
      logic [LW-1:0] d;

      #1 reset = 1'b0;
      step();
      step();
      reset  = 1'b1;
      cmp_en = 1'b1;
      check("rst_busy", LW'(busy), LW'(0));
      check("rst_mem_req", LW'(mem_req), LW'(0));

      // Single I read, memory answers three cycles after the request.
      reqI  = 1'b1;
      addrI = 26'h0040;
      step();
      check("t1_req", LW'(mem_req), LW'(1));
      check("t1_addr", LW'(mem_addr), LW'(26'h0040));
      check("t1_we", LW'(mem_we), LW'(0));
      step();
      step();
      mem_rready = 1'b1;
      mem_rdata  = {16{8'hA5}};
      step();
      mem_rready = 1'b0;
      check("t1_ready", LW'(readyI), LW'(1));
      check("t1_rdata", rdataI, {16{8'hA5}});
      check("t1_req_low", LW'(mem_req), LW'(0));
      reqI = 1'b0;
      step();
      check("t1_pulse_once", LW'(readyI), LW'(0));
      check("t1_hold", rdataI, {16{8'hA5}});
      step();

      // Contention straight out of reset: D first, then alternation.
      reset = 1'b0;
      step();
      reset = 1'b1;
      reqI  = 1'b1;
      addrI = 26'h0040;
      reqD  = 1'b1;
      weD   = 1'b0;
      addrD = 26'h0100;
      for (int k = 0; k < 4; k++) begin
         serve({4{32'h1000_0000 + 32'(k)}}, a);
         check($sformatf("alt%0d", k), LW'(a), LW'((k % 2 == 0) ? 26'h0100 : 26'h0040));
      end
      reqI = 1'b0;
      reqD = 1'b0;
      step();
      step();

      // D write; a read-ready pulse during it must not complete it.
      reqD   = 1'b1;
      weD    = 1'b1;
      addrD  = 26'h0200;
      wdataD = 128'h1234;
      wait_req();
      check("t3_we", LW'(mem_we), LW'(1));
      check("t3_wdata", mem_wdata, 128'h1234);
      check("t3_addr", LW'(mem_addr), LW'(26'h0200));
      mem_rready = 1'b1;
      step();
      mem_rready = 1'b0;
      check("t3_ignore_rready", LW'(mem_req), LW'(1));
      mem_wack = 1'b1;
      step();
      mem_wack = 1'b0;
      check("t3_ack", LW'(ackD), LW'(1));
      reqD = 1'b0;
      weD  = 1'b0;
      step();
      step();

      // Flushed I read completes silently; the next I read is normal.
      reqI  = 1'b1;
      addrI = 26'h0300;
      wait_req();
      flushI = 1'b1;
      reqI   = 1'b0;
      step();
      flushI = 1'b0;
      step();
      mem_rready = 1'b1;
      mem_rdata  = {4{32'hDEAD_BEEF}};
      step();
      mem_rready = 1'b0;
      check("t4_suppressed", LW'(readyI), LW'(0));
      check("t4_turn", LW'(mem_req), LW'(0));
      step();
      step();
      reqI  = 1'b1;
      addrI = 26'h0304;
      serve({4{32'h0BAD_F00D}}, a);
      check("t4_next_ready", LW'(readyI), LW'(1));
      check("t4_next_data", rdataI, {4{32'h0BAD_F00D}});
      reqI = 1'b0;
      step();
      step();

      // Memory never answers: watchdog fires after TO grant cycles.
      reqI  = 1'b1;
      addrI = 26'h0500;
      wait_req();
      repeat (TO - 1) step();
      check("t5_pre_err", LW'(timeout_err), LW'(0));
      check("t5_pre_req", LW'(mem_req), LW'(1));
      step();
      check("t5_err", LW'(timeout_err), LW'(1));
      check("t5_ready", LW'(readyI), LW'(1));
      check("t5_zero", rdataI, '0);
      reqI = 1'b0;
      step();
      mem_rready = 1'b1;
      step();
      mem_rready = 1'b0;
      check("t5_late", LW'(readyI), LW'(0));
      check("t5_idle", LW'(busy), LW'(0));
      repeat (5) step();
      check("t5_sticky", LW'(timeout_err), LW'(1));

      // Asynchronous reset in the middle of a D read.
      reqD  = 1'b1;
      weD   = 1'b0;
      addrD = 26'h0600;
      wait_req();
      step();
      #2 reset = 1'b0;
      #1;
      check("t6_req", LW'(mem_req), LW'(0));
      check("t6_busy", LW'(busy), LW'(0));
      check("t6_addr", LW'(mem_addr), '0);
      check("t6_err", LW'(timeout_err), LW'(0));
      check("t6_rdataI", rdataI, '0);
      reqD = 1'b0;
      step();
      reset = 1'b1;
      mem_rready = 1'b1;
      step();
      mem_rready = 1'b0;
      check("t6_stray", LW'(readyD), LW'(0));
      step();

      // Randomized traffic from both requesters against a noisy memory.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (reqI && m.readyI) begin
            reqI = 1'b0;
         end else if (!reqI && $urandom_range(2) == 0) begin
            reqI  = 1'b1;
            addrI = AW'($urandom());
         end
         flushI = ($urandom_range(15) == 0);
         if (reqD && (m.readyD || m.ackD)) begin
            reqD = 1'b0;
         end else if (!reqD && $urandom_range(2) == 0) begin
            reqD   = 1'b1;
            weD    = 1'($urandom_range(1));
            addrD  = AW'($urandom());
            wdataD = {$urandom(), $urandom(), $urandom(), $urandom()};
         end
         if (cyc % 150 == 0) silent = ($urandom_range(3) == 0);
         mem_rready = !silent && ($urandom_range(3) == 0);
         mem_wack   = !silent && ($urandom_range(3) == 0);
         mem_rdata  = {$urandom(), $urandom(), $urandom(), $urandom()};
         if ($urandom_range(599) == 0) begin
            reset = 1'b0;
            step();
            reset = 1'b1;
         end else begin
            step();
         end
      end

      reqI       = 1'b0;
      reqD       = 1'b0;
      flushI     = 1'b0;
      mem_rready = 1'b0;
      mem_wack   = 1'b0;
      repeat (20) step();
      cmp_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 128-bit-line main-memory port between the instruction-cache miss path (read-only) and the data-cache miss/writeback path (read/write).
- Sits between both caches and the memory model.
- Serialises one line transaction at a time, routes each response only to its owner, and enforces a watchdog on stalled transactions.

Parameters:
ADDR_W, 26, line-address width (matches cache request address)
LINE_W, 128, cache line width in bits
TIMEOUT, 255, max cycles a transaction may wait for a memory response; 0 disables the watchdog
CNT_W, 8, watchdog counter width; must hold TIMEOUT

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
reqI  in  1  I-side line read request, level, held until readyI
addrI  in  ADDR_W  I-side line address
flushI  in  1  pipeline flush; discards the in-flight I response
rdataI  out  LINE_W  line returned to the I-cache
readyI  out  1  one-cycle pulse: rdataI valid
reqD  in  1  D-side request, level, held until readyD/ackD
weD  in  1  D-side 1 = line write, 0 = line read
addrD  in  ADDR_W  D-side line address
wdataD  in  LINE_W  D-side writeback line
rdataD  out  LINE_W  line returned to the D-cache
readyD  out  1  one-cycle pulse: rdataD valid
ackD  out  1  one-cycle pulse: D write complete
mem_req  out  1  memory request, level
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory line address
mem_wdata  out  LINE_W  memory write line
mem_rdata  in  LINE_W  memory read line
mem_rready  in  1  one-cycle pulse: mem_rdata valid
mem_wack  in  1  one-cycle pulse: write done
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky; set on watchdog expiry, cleared only by reset

Behaviour:
- Reset (reset=0, async): state IDLE, last_grant=I, all outputs 0, watchdog 0, timeout_err 0.
- FSM states: IDLE, GRANT_I, GRANT_D, TURN.
- IDLE, request sampling:
  - Requests sampled at the clock edge.
  - Only reqI pending (and flushI=0): go to GRANT_I.
  - Only reqD pending: go to GRANT_D.
  - Both pending: grant the side opposite last_grant. After reset D wins first; otherwise the two sides alternate.
  - reqI with flushI=1 is not granted that cycle.
- On grant:
  - Address, we and wdata are captured into registers; last_grant is updated.
  - mem_req rises in the first cycle of the GRANT state (one cycle after the request was sampled).
  - mem_we=0 for I; mem_we=weD for D.
- GRANT_x: mem_req and mem_addr/mem_we/mem_wdata are held stable until the response arrives. The expected response is mem_rready for reads and mem_wack for writes. The non-matching pulse is ignored.
- Response (expected pulse sampled at edge of cycle N):
  - Cycle N+1: state TURN, mem_req=0.
  - Registered data goes to the owner: rdataI with readyI=1, or rdataD with readyD=1, or ackD=1.
  - Cycle N+2: IDLE.
  - The requester drops req in N+2; the arbiter samples again at the end of N+2.
- Fixed cost is one turnaround cycle with mem_req low between any two transactions.
- rdataI/rdataD hold their last value when not pulsing.
- flushI:
  - If asserted at any edge during GRANT_I, a sticky drop flag is set.
  - The memory transaction still completes and the arbiter passes through TURN, but readyI is suppressed.
  - flushI has no effect on D transactions.
- Watchdog:
  - Counts cycles in GRANT_x; cleared on entry to GRANT_x.
  - When the count reaches TIMEOUT with no response: timeout_err<=1, go to TURN, and deliver the ready/ack pulse to the owner with data=0 (so the requester cannot hang).
  - A late memory response arriving after timeout is ignored (IDLE/TURN ignore all memory pulses).
- Memory pulses in IDLE or TURN are always ignored.
- Reset mid-transaction: immediate return to IDLE with no response to any requester; a subsequent stray memory pulse is ignored.
- A response pulse and watchdog expiry in the same cycle: the response wins and timeout_err is not set.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, GRANT_I, GRANT_D, TURN}
  - grant enum {GNT_I, GNT_D}
  - default ADDR_W/LINE_W localparams
- Sub-module mem_arb_watchdog:
  - Inputs: clk, reset, clr, en.
  - Output: expired.
  - CNT_W counter compared to TIMEOUT; expired is never asserted when TIMEOUT=0.

Test Plan:
- reqI=1, addrI=26'h0040; memory returns mem_rready 3 cycles after mem_req with mem_rdata=128'hA5..A5 -> mem_addr=26'h0040, mem_we=0; readyI pulses once with rdataI=A5..A5; mem_req low for exactly one cycle afterwards.
- reqI and reqD(read, addrD=26'h0100) raised together out of reset, each held until served -> D granted first, I second; with both held continuously, grants alternate D,I,D,I.
- reqD=1, weD=1, addrD=26'h0200, wdataD=128'h1234 -> mem_we=1, mem_wdata=128'h1234; ackD pulses after mem_wack; a mem_rready pulse injected during that write is ignored.
- I read in flight, flushI pulsed one cycle, memory responds later -> readyI never asserts; the next reqI is served normally.
- TIMEOUT=8, memory never responds to an I read -> after 8 GRANT cycles timeout_err=1 and readyI pulses with rdataI=0; a late mem_rready is ignored; timeout_err stays 1 until reset.
- reset driven low mid D read -> all outputs 0 asynchronously; after release, a stray mem_rready produces no readyD.
